ring_buffer_fifo: RTL

//  Parametrised single-clock FIFO: any DATA_W, any DEPTH >= 2 (power of two not required).
//  Run-time selectable overflow policy: drop or overwrite-oldest.

---
 rtl/ring_fifo_pkg.sv | 14 +
 rtl/ring_ptr.sv | 26 ++
 rtl/ring_buffer_fifo.sv | 136 +++++++++++++
 3 files changed

// File: rtl/ring_fifo_pkg.sv
// rtl/ring_fifo_pkg.sv - shared types and width helpers for the ring buffer FIFO
package ring_fifo_pkg;

    typedef enum logic {OVF_DROP = 1'b0, OVF_OVERWRITE = 1'b1} ovf_mode_e;

    function automatic int ptr_w(input int depth);
        return ($clog2(depth) < 1) ? 1 : $clog2(depth);
    endfunction

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/ring_ptr.sv
// rtl/ring_ptr.sv - ring pointer with flush, increment enable and wrap at DEPTH-1
module ring_ptr
    import ring_fifo_pkg::*;
#(
    parameter int DEPTH = 16,
    localparam int PW = ptr_w(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          inc,
    output logic [PW-1:0] ptr
);

    // Explicit wrap compare so non-power-of-two depths stay in range.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (clr) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
        end
    end

endmodule

// File: rtl/ring_buffer_fifo.sv
// rtl/ring_buffer_fifo.sv - single-clock FIFO with drop/overwrite overflow policy and level flags
module ring_buffer_fifo
    import ring_fifo_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int AF_LVL = 14,
    parameter int AE_LVL = 2,
    localparam int PW = ptr_w(DEPTH),
    localparam int CW = cnt_w(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              ovw_mode,
    input  logic              wen,
    input  logic [DATA_W-1:0] wdata,
    input  logic              ren,
    output logic [DATA_W-1:0] rdata,
    output logic [CW-1:0]     count,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic              overflow,
    output logic              underflow
);

    if (DEPTH < 2) begin : g_depth_chk
        $error("ring_buffer_fifo: DEPTH must be >= 2");
    end
    if (AF_LVL < 1 || AF_LVL > DEPTH) begin : g_af_chk
        $error("ring_buffer_fifo: AF_LVL must be in 1..DEPTH");
    end
    if (AE_LVL < 0 || AE_LVL >= DEPTH) begin : g_ae_chk
        $error("ring_buffer_fifo: AE_LVL must be in 0..DEPTH-1");
    end

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wptr;
    logic [PW-1:0]     rptr;
    logic              wr_inc;
    logic              rd_inc;
    logic              store;
    logic [CW-1:0]     count_nxt;
    logic              ovf_nxt;
    logic              udf_nxt;
    ovf_mode_e         mode;

    assign mode  = ovf_mode_e'(ovw_mode);
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    always_comb begin
        wr_inc    = 1'b0;
        rd_inc    = 1'b0;
        store     = 1'b0;
        count_nxt = count;
        ovf_nxt   = 1'b0;
        udf_nxt   = 1'b0;
        if (wen && !ren) begin
            if (!full) begin
                store     = 1'b1;
                wr_inc    = 1'b1;
                count_nxt = count + CW'(1);
            end else begin
                ovf_nxt = 1'b1;
                if (mode == OVF_OVERWRITE) begin
                    store  = 1'b1;
                    wr_inc = 1'b1;
                    rd_inc = 1'b1;
                end
            end
        end else if (ren && !wen) begin
            if (!empty) begin
                rd_inc    = 1'b1;
                count_nxt = count - CW'(1);
            end else begin
                udf_nxt = 1'b1;
            end
        end else if (wen && ren) begin
            store  = 1'b1;
            wr_inc = 1'b1;
            if (empty) begin
                // Nothing to pop yet: the write lands, the read is reported.
                count_nxt = count + CW'(1);
                udf_nxt   = 1'b1;
            end else begin
                rd_inc = 1'b1;
            end
        end
    end

    ring_ptr #(.DEPTH(DEPTH)) u_wptr (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .inc (wr_inc),
        .ptr (wptr)
    );

    ring_ptr #(.DEPTH(DEPTH)) u_rptr (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .inc (rd_inc),
        .ptr (rptr)
    );

    always_ff @(posedge clk) begin
        if (store && !clr) begin
            mem[wptr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (clr) begin
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            count     <= count_nxt;
            overflow  <= ovf_nxt;
            underflow <= udf_nxt;
        end
    end

    assign rdata        = empty ? '0 : mem[rptr];
    assign almost_full  = (count >= CW'(AF_LVL));
    assign almost_empty = (count <= CW'(AE_LVL));

endmodule
